// File: rtl/proc_pkg.sv
// Shared definitions for the processor control unit.
//   - opcode constants for the 2-bit opcode field
//   - control-step state encoding T0..T3
//   - instruction field positions and extraction helpers (8-bit word:
//     opcode [7:6], X [5:3], Y [2:0])
package proc_pkg;

  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam int unsigned OP_HI = 7;
  localparam int unsigned OP_LO = 6;
  localparam int unsigned X_HI  = 5;
  localparam int unsigned X_LO  = 3;
  localparam int unsigned Y_HI  = 2;
  localparam int unsigned Y_LO  = 0;

  function automatic logic [1:0] ir_op(input logic [7:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction

  function automatic logic [2:0] ir_x(input logic [7:0] ir);
    return ir[X_HI:X_LO];
  endfunction

  function automatic logic [2:0] ir_y(input logic [7:0] ir);
    return ir[Y_HI:Y_LO];
  endfunction

endpackage

// File: rtl/proc_ctrl_fsm_dec3to8.sv
// dec3to8: 3-to-8 one-hot decoder with enable.
//   w  : 3-bit index
//   en : when low the output is all zeros
//   y  : one-hot output, bit w set when enabled
module dec3to8 (
  input  logic [2:0] w,
  input  logic       en,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    if (en) y[w] = 1'b1;
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// proc_ctrl_fsm: multi-cycle control unit for the 8-register, 8-bit
// processor datapath (R0..R7, A, G, add/sub ALU, shared bus).
// Fetches an instruction from DIN in T0 when Run is high, then sequences
// the datapath through T1..T3 with one-hot register strobes and bus-source
// selects. Done pulses in the last cycle of each instruction.
//
// Ports:
//   Clock   : system clock, rising edge
//   Reset   : asynchronous active-high reset (state=T0, IR=0)
//   Run     : start request, sampled only in T0
//   DIN     : instruction word in T0, immediate in T1 of mvi
//   IRin    : IR load strobe
//   Rin     : one-hot register write enables R0..R7
//   Rout    : one-hot register bus-drive selects R0..R7
//   DINout  : DIN drives the bus
//   Gout    : G drives the bus
//   Ain     : A load strobe
//   Gin     : G load strobe
//   AddSub  : 0 = add, 1 = subtract
//   Done    : one-cycle completion pulse
//   Busy    : high whenever state is not T0
//   ADDR    : fetch address (only with PROC_CTRL_FETCH_EN defined)
//
// Build option: define PROC_CTRL_FETCH_EN to add the ADDR fetch counter,
// which advances on each instruction fetch and each consumed mvi immediate.
module proc_ctrl_fsm
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic              IRin,
  output logic [7:0]        Rin,
  output logic [7:0]        Rout,
  output logic              DINout,
  output logic              Gout,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic              Done,
`ifdef PROC_CTRL_FETCH_EN
  output logic [ADDR_W-1:0] ADDR,
`endif
  output logic              Busy
);

  if (DATA_W != 8 || ADDR_W == 0) begin : g_param_chk
    $error("proc_ctrl_fsm: DATA_W must be 8 and ADDR_W non-zero");
  end

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] ir;

  logic [1:0] op;
  logic [2:0] fx;
  logic [2:0] fy;

  logic       rin_en;
  logic       rout_en;
  logic [2:0] rin_sel;
  logic [2:0] rout_sel;

  assign op = ir_op(ir);
  assign fx = ir_x(ir);
  assign fy = ir_y(ir);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (IRin) ir <= DIN;
    end
  end

  // Outputs are gated by Reset so the whole control word is quiet while
  // reset is held, even in T0 with Run high.
  always_comb begin
    state_nxt = state;
    IRin      = 1'b0;
    DINout    = 1'b0;
    Gout      = 1'b0;
    Ain       = 1'b0;
    Gin       = 1'b0;
    AddSub    = 1'b0;
    Done      = 1'b0;
    Busy      = 1'b0;
    rin_en    = 1'b0;
    rout_en   = 1'b0;
    rin_sel   = fx;
    rout_sel  = fy;

    if (!Reset) begin
      Busy = (state != T0);
      case (state)
        T0: begin
          if (Run) begin
            IRin      = 1'b1;
            state_nxt = T1;
          end
        end
        T1: begin
          case (op)
            OP_MV: begin
              rout_en   = 1'b1;
              rout_sel  = fy;
              rin_en    = 1'b1;
              rin_sel   = fx;
              Done      = 1'b1;
              state_nxt = T0;
            end
            OP_MVI: begin
              DINout    = 1'b1;
              rin_en    = 1'b1;
              rin_sel   = fx;
              Done      = 1'b1;
              state_nxt = T0;
            end
            default: begin
              rout_en   = 1'b1;
              rout_sel  = fx;
              Ain       = 1'b1;
              state_nxt = T2;
            end
          endcase
        end
        T2: begin
          rout_en   = 1'b1;
          rout_sel  = fy;
          Gin       = 1'b1;
          AddSub    = ir[OP_LO];
          state_nxt = T3;
        end
        T3: begin
          Gout      = 1'b1;
          rin_en    = 1'b1;
          rin_sel   = fx;
          Done      = 1'b1;
          state_nxt = T0;
        end
        default: state_nxt = T0;
      endcase
    end
  end

  dec3to8 u_rin_dec (
    .w  (rin_sel),
    .en (rin_en),
    .y  (Rin)
  );

  dec3to8 u_rout_dec (
    .w  (rout_sel),
    .en (rout_en),
    .y  (Rout)
  );

`ifdef PROC_CTRL_FETCH_EN
  // DINout is only ever high in T1 of mvi, i.e. when the immediate word
  // is consumed, so it doubles as the second advance condition.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ADDR <= '0;
    end else if (IRin || DINout) begin
      ADDR <= ADDR + ADDR_W'(1);
    end
  end
`endif

endmodule

// File: doc/proc_ctrl_fsm.md
Name: proc_ctrl_fsm

Overview:
- Multi-cycle control unit for the 8-register, 8-bit processor datapath: register file R0..R7, A register, G register, add/sub ALU, shared bus.
- Fetches an instruction word from DIN when Run is high and latches it into an internal IR.
- Sequences the datapath through T0..T3 by driving one-hot register-select strobes and bus-source selects; signals completion with Done.
- Replaces the ad hoc cal_flag sequencing; sits between the instruction ROM/counter and the register-file/ALU datapath.

Parameters:
- DATA_W, 8, instruction/data word width. Only 8 is supported: opcode field is [7:6], X is [5:3], Y is [2:0].
- ADDR_W, 5, fetch address width. Used only when PROC_CTRL_FETCH_EN is defined.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Run  input  1  start request; sampled only in state T0.
- DIN  input  DATA_W  instruction word in T0; immediate operand in T1 for mvi.
- IRin  output  1  IR load strobe; asserted in T0 when Run=1.
- Rin  output  8  one-hot register-file write enable for R0..R7.
- Rout  output  8  one-hot register-file bus-drive select for R0..R7.
- DINout  output  1  DIN drives the bus.
- Gout  output  1  G drives the bus.
- Ain  output  1  A load strobe.
- Gin  output  1  G load strobe.
- AddSub  output  1  ALU op select: 0 = add, 1 = subtract.
- Done  output  1  one-cycle pulse in the final cycle of each instruction.
- Busy  output  1  high whenever state is not T0.

Behaviour:
- State register and IR are clocked on posedge Clock. Reset forces state=T0 and IR=0 asynchronously.
- All control outputs are combinational decodes of (state, IR, Run), so every output is 0 while Reset is high.
- Datapath registers capture on the same edge that ends the cycle in which their strobe is high.
- Opcodes: 00 = mv X,Y; 01 = mvi X,#D; 10 = add X,Y; 11 = sub X,Y.
- T0:
  - Run=0: all outputs 0; stay in T0.
  - Run=1: IRin=1; IR<=DIN; go to T1.
- T1, mv: Rout[Y]=1, Rin[X]=1, Done=1; go to T0. Case X==Y is legal and leaves the register unchanged.
- T1, mvi: DINout=1, Rin[X]=1, Done=1; go to T0. DIN must carry the immediate in this cycle.
- T1, add/sub: Rout[X]=1, Ain=1; go to T2.
- T2: Rout[Y]=1, Gin=1, AddSub=IR[6]; go to T3.
- T3: Gout=1, Rin[X]=1, Done=1; go to T0.
- Latency:
  - mv/mvi: 2 cycles from the Run-sampled edge, Done in the 2nd cycle.
  - add/sub: 4 cycles, Done in T3.
- Run is ignored in T1..T3. Holding Run high back-to-back starts the next fetch in the cycle after Done; there are no idle gaps beyond T0.
- At most one bit of Rout, and at most one of {any Rout, DINout, Gout}, is high in any cycle. This is the bus-exclusivity invariant.
- Reset asserted mid-instruction aborts immediately; no partial Rin write completes after Reset is released.
- The unused state encoding recovers to T0 on the next clock with all outputs 0.

Optional Feature:
- Macro: PROC_CTRL_FETCH_EN.
- When defined:
  - Adds output ADDR [ADDR_W-1:0], reset 0.
  - ADDR increments by 1 on each edge where IRin=1, and on each edge ending the T1 cycle of an mvi (immediate consumed).
  - Wraps from 2^ADDR_W-1 to 0.
  - The ROM is addressed directly by ADDR, replacing the free-running manual counter.
- When undefined: no ADDR port, no counter logic; the external source must present the correct word on DIN.

Decomposition:
- Shared package proc_pkg holds:
  - opcode constants OP_MV=2'b00, OP_MVI=2'b01, OP_ADD=2'b10, OP_SUB=2'b11;
  - state encoding T0..T3 (2-bit);
  - field slice positions for opcode, X and Y.
- One sub-module: dec3to8, a 3-to-8 one-hot decoder with enable, instantiated twice for Rin and Rout.

Test Plan:
- Reset=1 mid-T2 of an add -> state=T0, IR=0, all outputs 0 immediately. After release with Run=0, Busy stays 0.
- Run=1, DIN=8'b01_010_000 (mvi R2) then DIN=8'h5A -> T0: IRin=1; T1: DINout=1, Rin=8'b0000_0100, Done=1. With FETCH_EN: ADDR 0 -> 2.
- DIN=8'b00_001_011 (mv R1,R3) -> T1: Rout=8'b0000_1000, Rin=8'b0000_0010, Done=1. Total 2 cycles.
- DIN=8'b11_000_001 (sub R0,R1) ->
  - T1: Rout=8'h01, Ain=1;
  - T2: Rout=8'h02, Gin=1, AddSub=1;
  - T3: Gout=1, Rin=8'h01, Done=1.
- Run toggled high during T1..T3 of an add -> no effect; next IRin only in a T0 with Run=1. Run held high continuously gives back-to-back instructions.
- Random 2000-instruction stream with assertions -> bus exclusivity holds every cycle, Done count equals IRin count, and FETCH_EN ADDR wraps 31 -> 0.
